// File: rtl/bridge_pkg.sv
// -----------------------------------------------------------------------------
// bridge_pkg
// Shared definitions for the SPI-to-UART bridge:
//   - ASCII constants used by the hex-text formatter
//   - egress state encoding (3-bit)
//   - nibble_to_ascii(): 4-bit value -> uppercase hex digit character
// -----------------------------------------------------------------------------
package bridge_pkg;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_SP   = 8'h20;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_A    = 8'h41;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RAW  = 3'd1,
        ST_HI   = 3'd2,
        ST_LO   = 3'd3,
        ST_SEP  = 3'd4,
        ST_CR   = 3'd5,
        ST_LF   = 3'd6,
        ST_GAP  = 3'd7
    } egress_state_e;

    // Uppercase hex digit: 0-9 -> '0'-'9', 10-15 -> 'A'-'F'.
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_ZERO + {4'h0, nib};
        end
        return ASCII_A + {4'h0, nib} - 8'd10;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered occupancy flags.
//   clk, rst       : clock, asynchronous active-high reset
//   wr_en, wr_data : push request and data; accepted when not full, or when
//                    full but a pop is accepted on the same edge
//   rd_en, rd_data : pop request; rd_data always shows the head entry
//   level          : registered occupancy, 0..DEPTH
//   full, empty    : registered flags derived from the next level
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             wr_fire, rd_fire;

    // NOTE: every variable assigned in an always_comb gets a default on entry,
    // otherwise a path that skips the assignment infers a latch.
    always_comb begin
        rd_fire  = rd_en && !empty_q;
        wr_fire  = wr_en && (!full_q || rd_fire);
        wr_ptr_d = wr_fire ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = rd_fire ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (wr_fire && !rd_fire) begin
            level_d = level_q + LW'(1);
        end else if (rd_fire && !wr_fire) begin
            level_d = level_q - LW'(1);
        end
        empty_d = (level_d == '0);
        full_d  = (level_d == LW'(DEPTH));
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and
    // level define which entries are valid, so stale contents are harmless.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign level   = level_q;
    assign full    = full_q;
    assign empty   = empty_q;

endmodule

// File: rtl/spi_uart_bridge.sv
// -----------------------------------------------------------------------------
// spi_uart_bridge
// Buffers bytes received by the SPI slave and streams them to the UART
// transmitter, either raw or as uppercase hex-ASCII text with space
// separators and CR/LF line breaks every LINE_BYTES bytes.
//   system_clk, reset  : clock, asynchronous active-high reset
//   hex_mode           : 0 raw, 1 hex text; sampled when a byte is popped
//   spi_data_ready     : level, SPI byte valid until acknowledged
//   spi_rx_data        : received SPI byte
//   spi_read_ack       : one-cycle pulse consuming the current SPI byte
//   spi_data_to_send   : status {overflow_flag, level saturated at 127}
//   uart_tx_fifo_ready : UART can take a character this cycle
//   start_uart_tx      : one-cycle launch pulse for uart_tx_data
//   uart_tx_data       : character; held from a pulse until the next pulse
//   fifo_level         : buffer occupancy
//   overflow_count     : bytes dropped on a full buffer, saturating
// -----------------------------------------------------------------------------
module spi_uart_bridge #(
    parameter int FIFO_DEPTH = 16,
    parameter int LINE_BYTES = 16,
    parameter int OVF_WIDTH  = 8
) (
    input  logic                          system_clk,
    input  logic                          reset,
    input  logic                          hex_mode,
    input  logic                          spi_data_ready,
    input  logic [7:0]                    spi_rx_data,
    output logic                          spi_read_ack,
    output logic [7:0]                    spi_data_to_send,
    input  logic                          uart_tx_fifo_ready,
    output logic                          start_uart_tx,
    output logic [7:0]                    uart_tx_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [OVF_WIDTH-1:0]          overflow_count
);

    import bridge_pkg::*;

    localparam logic [7:0] LINE_LAST = 8'(LINE_BYTES);

    // ---------------------------------------------------------------- ingress
    logic                 ack_q, ack_d;
    logic                 byte_taken_q, byte_taken_d;
    logic                 ovf_flag_q, ovf_flag_d;
    logic [OVF_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;
    logic [7:0]           status_q, status_d;
    logic [6:0]           level_sat;
    logic                 drop;

    // ---------------------------------------------------------------- buffer
    logic                 fifo_full, fifo_empty;
    logic [7:0]           fifo_rd_data;
    logic                 pop;

    // ---------------------------------------------------------------- egress
    egress_state_e        state_q, ret_q;
    logic [7:0]           cur_byte_q;
    logic [7:0]           line_cnt_q;
    logic [7:0]           last_char_q;
    logic [7:0]           emit_char;
    logic                 emit_req;

    // A byte is taken on the first cycle spi_data_ready is seen high; the
    // taken flag follows spi_data_ready, so it clears once the level drops.
    always_comb begin
        ack_d        = spi_data_ready && !byte_taken_q;
        byte_taken_d = spi_data_ready;

        // A full buffer still accepts a push if the head leaves on that edge.
        drop = ack_q && fifo_full && !pop;

        ovf_cnt_d = ovf_cnt_q;
        if (drop && (ovf_cnt_q != '1)) begin
            ovf_cnt_d = ovf_cnt_q + OVF_WIDTH'(1);
        end

        // Sticky until a byte arrives at an empty buffer.
        ovf_flag_d = ovf_flag_q;
        if (ack_q && fifo_empty) begin
            ovf_flag_d = 1'b0;
        end else if (drop) begin
            ovf_flag_d = 1'b1;
        end

        if (32'(fifo_level) > 32'd127) begin
            level_sat = 7'h7F;
        end else begin
            level_sat = 7'(fifo_level);
        end
        status_d = {ovf_flag_q, level_sat};
    end

    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            ack_q        <= 1'b0;
            byte_taken_q <= 1'b0;
            ovf_flag_q   <= 1'b0;
            ovf_cnt_q    <= '0;
            status_q     <= '0;
        end else begin
            ack_q        <= ack_d;
            byte_taken_q <= byte_taken_d;
            ovf_flag_q   <= ovf_flag_d;
            ovf_cnt_q    <= ovf_cnt_d;
            status_q     <= status_d;
        end
    end

    // The byte is pushed on the edge that ends the ack cycle; the SPI slave
    // keeps spi_rx_data valid until that acknowledge completes.
    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (system_clk),
        .rst     (reset),
        .wr_en   (ack_q),
        .wr_data (spi_rx_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Character offered by the current state. The launch pulse is qualified
    // combinationally by uart_tx_fifo_ready so it lands in the same cycle the
    // UART reports space. A pending separator is only sent once another byte
    // is buffered, so a line never ends in a dangling space.
    always_comb begin
        emit_char = last_char_q;
        emit_req  = 1'b0;
        case (state_q)
            ST_RAW: begin
                emit_char = cur_byte_q;
                emit_req  = 1'b1;
            end
            ST_HI: begin
                emit_char = nibble_to_ascii(cur_byte_q[7:4]);
                emit_req  = 1'b1;
            end
            ST_LO: begin
                emit_char = nibble_to_ascii(cur_byte_q[3:0]);
                emit_req  = 1'b1;
            end
            ST_SEP: begin
                emit_char = ASCII_SP;
                emit_req  = !fifo_empty;
            end
            ST_CR: begin
                emit_char = ASCII_CR;
                emit_req  = 1'b1;
            end
            ST_LF: begin
                emit_char = ASCII_LF;
                emit_req  = 1'b1;
            end
            default: begin
                emit_char = last_char_q;
                emit_req  = 1'b0;
            end
        endcase

        start_uart_tx = emit_req && uart_tx_fifo_ready;
        uart_tx_data  = start_uart_tx ? emit_char : last_char_q;

        // Bytes stay buffered while the UART is busy, so backpressure shows
        // up in fifo_level rather than in a byte parked in cur_byte_q.
        pop = (state_q == ST_IDLE) && !fifo_empty && uart_tx_fifo_ready;
    end

    // Egress FSM. Every emitting state moves to GAP on its pulse, with ret_q
    // holding the state to resume after the idle cycle.
    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ret_q       <= ST_IDLE;
            cur_byte_q  <= '0;
            line_cnt_q  <= '0;
            last_char_q <= '0;
        end else begin
            if (start_uart_tx) begin
                last_char_q <= emit_char;
            end
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        cur_byte_q <= fifo_rd_data;
                        state_q    <= hex_mode ? ST_HI : ST_RAW;
                    end
                end
                ST_RAW: begin
                    if (start_uart_tx) begin
                        ret_q   <= ST_IDLE;
                        state_q <= ST_GAP;
                    end
                end
                ST_HI: begin
                    if (start_uart_tx) begin
                        ret_q   <= ST_LO;
                        state_q <= ST_GAP;
                    end
                end
                ST_LO: begin
                    if (start_uart_tx) begin
                        line_cnt_q <= line_cnt_q + 8'd1;
                        ret_q      <= (line_cnt_q + 8'd1 == LINE_LAST) ? ST_CR : ST_SEP;
                        state_q    <= ST_GAP;
                    end
                end
                ST_SEP: begin
                    if (start_uart_tx) begin
                        ret_q   <= ST_IDLE;
                        state_q <= ST_GAP;
                    end
                end
                ST_CR: begin
                    if (start_uart_tx) begin
                        ret_q   <= ST_LF;
                        state_q <= ST_GAP;
                    end
                end
                ST_LF: begin
                    if (start_uart_tx) begin
                        line_cnt_q <= '0;
                        ret_q      <= ST_IDLE;
                        state_q    <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    state_q <= ret_q;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign spi_read_ack     = ack_q;
    assign spi_data_to_send = status_q;
    assign overflow_count   = ovf_cnt_q;

endmodule

// File: tb/tb_spi_uart_bridge.sv
// -----------------------------------------------------------------------------
// tb_spi_uart_bridge
// Directed bench for spi_uart_bridge with FIFO_DEPTH = 4, LINE_BYTES = 2.
// Inputs are driven and outputs compared 2 time units after each rising
// edge; a monitor on the falling edge records every UART character.
// -----------------------------------------------------------------------------
module tb_spi_uart_bridge;

    logic       clk = 1'b0;
    logic       reset;
    logic       hex_mode;
    logic       spi_data_ready;
    logic [7:0] spi_rx_data;
    logic       spi_read_ack;
    logic [7:0] spi_data_to_send;
    logic       uart_tx_fifo_ready;
    logic       start_uart_tx;
    logic [7:0] uart_tx_data;
    logic [2:0] fifo_level;
    logic [7:0] overflow_count;

    int tests = 0;
    int fails = 0;

    logic [7:0] tx_q[$];
    int         ack_cnt   = 0;
    int         cyc       = 0;
    int         last_cyc  = 0;
    bit         have_last = 1'b0;
    logic [7:0] last_char = 8'h00;
    int         gap_err   = 0;
    int         hold_err  = 0;

    spi_uart_bridge #(
        .FIFO_DEPTH (4),
        .LINE_BYTES (2),
        .OVF_WIDTH  (8)
    ) dut (
        .system_clk         (clk),
        .reset              (reset),
        .hex_mode           (hex_mode),
        .spi_data_ready     (spi_data_ready),
        .spi_rx_data        (spi_rx_data),
        .spi_read_ack       (spi_read_ack),
        .spi_data_to_send   (spi_data_to_send),
        .uart_tx_fifo_ready (uart_tx_fifo_ready),
        .start_uart_tx      (start_uart_tx),
        .uart_tx_data       (uart_tx_data),
        .fifo_level         (fifo_level),
        .overflow_count     (overflow_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Character capture, pulse spacing and data-hold monitor.
    always @(negedge clk) begin
        if (reset) begin
            have_last = 1'b0;
        end else begin
            if (spi_read_ack) ack_cnt++;
            if (start_uart_tx) begin
                if (have_last && (cyc - last_cyc < 2)) gap_err++;
                tx_q.push_back(uart_tx_data);
                last_char = uart_tx_data;
                last_cyc  = cyc;
                have_last = 1'b1;
            end else if (have_last && (uart_tx_data !== last_char)) begin
                hold_err++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got = 1'b0;
        spi_rx_data    = b;
        spi_data_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (spi_read_ack) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("ack_timeout", 32'(got), 32'd1);
        step();
        spi_data_ready = 1'b0;
        step();
    endtask

    task automatic wait_tx(input int n, input int bound);
        for (int i = 0; i < bound && tx_q.size() < n; i++) step();
    endtask

    // exp holds n characters, first character in the most significant byte.
    task automatic check_stream(input string tag, input logic [127:0] exp, input int n);
        logic [127:0] e;
        e = exp;
        check({tag, "_len"}, 32'(tx_q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < tx_q.size()) check(tag, 32'(tx_q[i]), 32'(e[8*(n-1-i) +: 8]));
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ack"},    32'(spi_read_ack),     32'd0);
        check({tag, "_start"},  32'(start_uart_tx),    32'd0);
        check({tag, "_data"},   32'(uart_tx_data),     32'h00);
        check({tag, "_status"}, 32'(spi_data_to_send), 32'h00);
        check({tag, "_level"},  32'(fifo_level),       32'd0);
        check({tag, "_ovf"},    32'(overflow_count),   32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack0;

        reset              = 1'b1;
        hex_mode           = 1'b0;
        spi_data_ready     = 1'b0;
        spi_rx_data        = 8'h00;
        uart_tx_fifo_ready = 1'b0;
        step();
        step();
        check_reset_values("por");
        reset              = 1'b0;
        uart_tx_fifo_ready = 1'b1;
        step();

        // Raw mode: latency of ack and first pulse, then a second byte.
        ack0           = ack_cnt;
        spi_rx_data    = 8'h41;
        spi_data_ready = 1'b1;
        step();
        check("raw_ack", 32'(spi_read_ack), 32'd1);
        step();
        check("raw_ack_once", 32'(spi_read_ack), 32'd0);
        check("raw_level", 32'(fifo_level), 32'd1);
        check("raw_no_early_start", 32'(start_uart_tx), 32'd0);
        spi_data_ready = 1'b0;
        step();
        check("raw_start_latency", 32'(start_uart_tx), 32'd1);
        check("raw_first_char", 32'(uart_tx_data), 32'h41);
        send_byte(8'h42);
        wait_tx(2, 50);
        repeat (5) step();
        check_stream("raw_stream", 128'h4142, 2);
        check("raw_acks", 32'(ack_cnt - ack0), 32'd2);

        // Hex mode with a two-byte line, then a held separator.
        tx_q.delete();
        hex_mode = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h0F);
        send_byte(8'h3C);
        wait_tx(9, 200);
        repeat (20) step();
        check_stream("hex_line", {"A5 0F", 8'h0D, 8'h0A, "3C"}, 9);
        send_byte(8'h7E);
        wait_tx(14, 200);
        repeat (10) step();
        check_stream("hex_sep_after_hold", {"A5 0F", 8'h0D, 8'h0A, "3C 7E", 8'h0D, 8'h0A}, 14);

        // Overflow with the UART stalled.
        tx_q.delete();
        hex_mode           = 1'b0;
        uart_tx_fifo_ready = 1'b0;
        ack0               = ack_cnt;
        for (int i = 0; i < 6; i++) send_byte(8'h10 + 8'(i));
        check("ovf_acks", 32'(ack_cnt - ack0), 32'd6);
        check("ovf_level", 32'(fifo_level), 32'd4);
        check("ovf_count", 32'(overflow_count), 32'd2);
        check("ovf_status", 32'(spi_data_to_send), 32'h84);

        // Push and pop on the same edge while full.
        spi_rx_data    = 8'h16;
        spi_data_ready = 1'b1;
        step();
        check("full_pushpop_ack", 32'(spi_read_ack), 32'd1);
        uart_tx_fifo_ready = 1'b1;
        step();
        check("full_pushpop_level", 32'(fifo_level), 32'd4);
        check("full_pushpop_ovf", 32'(overflow_count), 32'd2);
        spi_data_ready = 1'b0;
        wait_tx(5, 100);
        repeat (5) step();
        check_stream("ovf_release", 128'h1011121316, 5);
        check("ovf_flag_sticky", 32'(spi_data_to_send), 32'h80);

        // Flag clears when a byte arrives at an empty buffer.
        send_byte(8'h20);
        wait_tx(6, 50);
        repeat (4) step();
        check("ovf_flag_clear", 32'(spi_data_to_send), 32'h00);
        check("ovf_count_kept", 32'(overflow_count), 32'd2);

        // Counter saturation.
        uart_tx_fifo_ready = 1'b0;
        for (int i = 0; i < 260; i++) send_byte(8'(i));
        check("ovf_saturate", 32'(overflow_count), 32'd255);
        check("sat_level", 32'(fifo_level), 32'd4);
        check("sat_status", 32'(spi_data_to_send), 32'h84);

        // Asynchronous reset from a busy, overflowed state.
        reset = 1'b1;
        #1;
        check_reset_values("rst_async");
        step();
        step();
        reset = 1'b0;
        step();

        // Backpressure between HI and LO, then reset mid-character.
        tx_q.delete();
        hex_mode           = 1'b1;
        uart_tx_fifo_ready = 1'b1;
        send_byte(8'h5A);
        wait_tx(2, 50);
        send_byte(8'hC3);
        for (int i = 0; i < 40; i++) begin
            if (tx_q.size() > 0 && tx_q[tx_q.size()-1] == 8'h43) break;
            step();
        end
        uart_tx_fifo_ready = 1'b0;
        repeat (5) step();
        check_stream("bp_stream", {"5A C"}, 4);
        check("bp_data_hold", 32'(uart_tx_data), 32'h43);
        check("bp_no_pulse", 32'(start_uart_tx), 32'd0);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        check("bp_buffered", 32'(fifo_level), 32'd3);
        reset = 1'b1;
        #1;
        check_reset_values("rst_mid");
        step();
        step();
        reset = 1'b0;
        step();
        tx_q.delete();
        uart_tx_fifo_ready = 1'b1;
        send_byte(8'h11);
        send_byte(8'h22);
        wait_tx(7, 150);
        repeat (10) step();
        check_stream("post_reset", {"11 22", 8'h0D, 8'h0A}, 7);

        check("pulse_spacing", 32'(gap_err), 32'd0);
        check("tx_data_hold", 32'(hold_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
